// File: rtl/dptr_multicycle.sv
// Multi-cycle MIPS datapath: R-type ALU ops, plus LW/SW and data memory when
// DPTR_MEM_EN is defined. One instruction at a time behind a valid/ready handshake.
module dptr_multicycle #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              done,
  output logic              err,
  output logic              zflag,
  output logic [DATA_W-1:0] result,
  input  logic [4:0]        dbg_ra,
  output logic [DATA_W-1:0] dbg_rd
);

`ifdef DPTR_MEM_EN
  typedef enum logic [2:0] {S_IDLE, S_DEC, S_EXE, S_MEM, S_WB} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXE, S_WB} state_t;
`endif
  typedef enum logic [1:0] {C_R, C_LW, C_SW, C_ILL} cls_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT} op_t;

  state_t            state, state_d;
  cls_t              cls_q, dec_cls;
  op_t               op_q, dec_op;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_b, alu_y, rf_wd;
  logic [DATA_W-1:0] rf [32];
  logic              rf_we;
  logic [4:0]        rf_wa;

`ifdef DPTR_MEM_EN
  localparam int unsigned AW = $clog2(DMEM_DEPTH);
  logic [DATA_W-1:0] imm, mdr;
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [AW-1:0]     maddr;

  // Sign-extend imm16 to DATA_W; narrower datapaths keep only the low bits.
  for (genvar g = 0; g < DATA_W; g++) begin : g_imm
    if (g < 16) begin : g_lo
      assign imm[g] = ir[g];
    end else begin : g_hi
      assign imm[g] = ir[15];
    end
  end

  assign maddr = result[AW-1:0];
`else
  logic unused_nomem;
  assign unused_nomem = ^{ir[10:6], 32'(DMEM_DEPTH)};
`endif

  // Instruction decode from the latched IR.
  always_comb begin
    dec_cls = C_ILL;
    dec_op  = OP_ADD;
    if (ir[31:26] == 6'h00) begin
      dec_cls = C_R;
      case (ir[5:0])
        6'h20:   dec_op = OP_ADD;
        6'h22:   dec_op = OP_SUB;
        6'h24:   dec_op = OP_AND;
        6'h25:   dec_op = OP_OR;
        6'h27:   dec_op = OP_NOR;
        6'h2A:   dec_op = OP_SLT;
        default: dec_cls = C_ILL;
      endcase
    end
`ifdef DPTR_MEM_EN
    else if (ir[31:26] == 6'h23) begin
      dec_cls = C_LW;
    end else if (ir[31:26] == 6'h2B) begin
      dec_cls = C_SW;
    end
`endif
  end

  always_comb begin
    alu_b = b;
`ifdef DPTR_MEM_EN
    if (cls_q != C_R) alu_b = imm;
`endif
  end

  always_comb begin
    alu_y = '0;
    case (op_q)
      OP_ADD:  alu_y = a + alu_b;
      OP_SUB:  alu_y = a - alu_b;
      OP_AND:  alu_y = a & alu_b;
      OP_OR:   alu_y = a | alu_b;
      OP_NOR:  alu_y = ~(a | alu_b);
      OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d     = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DEC;
      end
      S_DEC: state_d = (dec_cls == C_ILL) ? S_WB : S_EXE;
`ifdef DPTR_MEM_EN
      S_EXE: state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      S_MEM: state_d = S_WB;
`else
      S_EXE: state_d = S_WB;
`endif
      S_WB: begin
        done    = 1'b1;
        err     = (cls_q == C_ILL);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      cls_q  <= C_ILL;
      op_q   <= OP_ADD;
      result <= '0;
      zflag  <= 1'b0;
`ifdef DPTR_MEM_EN
      mdr    <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (instr_valid) ir <= instr;
        S_DEC: begin
          a     <= rf[ir[25:21]];
          b     <= rf[ir[20:16]];
          cls_q <= dec_cls;
          op_q  <= dec_op;
        end
        S_EXE: begin
          result <= alu_y;
          zflag  <= (alu_y == '0);
        end
`ifdef DPTR_MEM_EN
        S_MEM: mdr <= dmem[maddr];
`endif
        default: ;
      endcase
    end
  end

`ifdef DPTR_MEM_EN
  always_ff @(posedge clk) begin
    if (!rst && state == S_MEM && cls_q == C_SW) dmem[maddr] <= b;
  end
`endif

  // R-type writes rd from ALUOut; LW writes rt from MDR.
  always_comb begin
    rf_we = (state == S_WB) && (cls_q == C_R);
    rf_wa = ir[15:11];
    rf_wd = result;
`ifdef DPTR_MEM_EN
    if (cls_q == C_LW) begin
      rf_we = (state == S_WB);
      rf_wa = ir[20:16];
      rf_wd = mdr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf <= '{default: '0};
    end else if (rf_we && rf_wa != 5'd0) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  assign dbg_rd = (dbg_ra == 5'd0) ? '0 : rf[dbg_ra];

endmodule

// File: doc/dptr_multicycle.md
# dptr_multicycle

Parametrised multi-cycle datapath executing one MIPS R-type or load/store instruction at a time. It contains a register file, ALU, ALU decode, data memory and a control FSM. It is the clocked successor of the single-cycle R-type datapath, adding configurable data width and memory depth, an instruction valid/ready handshake, a completion pulse and illegal-instruction reporting. It sits between an instruction source (testbench or future fetch unit) and the verification/debug ports.

## Interface
- DATA_W, 32, datapath and register width; legal range 8..64
- DMEM_DEPTH, 64, data-memory depth in words; power of two, >= 4
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction presented
- instr  in  32  MIPS-format instruction
- instr_ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, concurrent with done, for an illegal instruction
- zflag  out  1  registered zero flag of the last legal ALU operation
- result  out  DATA_W  registered ALU output of the last legal instruction
- dbg_ra  in  5  debug register address
- dbg_rd  out  DATA_W  combinational read of register dbg_ra; r0 reads 0

## Operation
- Supported instructions:
  - R-type (opcode 0), selected by funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A (signed compare, result 1 or 0).
  - LW, opcode 0x23.
  - SW, opcode 0x2B.
- Any other opcode or funct is illegal: no register or memory write, zflag and result unchanged, err pulses.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch instr into IR and go to DEC.
  - DEC: read rs=IR[25:21] and rt=IR[20:16] into A and B. Sign-extend IR[15:0] to DATA_W, truncating if DATA_W<16. Decode the instruction. Go to EXE, or to WB with an illegal flag.
  - EXE: R-type computes A op B. LW/SW compute A+imm. Latch ALUOut into result and set zflag=(ALUOut==0). Go to MEM for LW/SW, otherwise WB.
  - MEM: memory word address is ALUOut[log2(DMEM_DEPTH)-1:0], wrapping modulo depth. SW writes B on the exit edge. LW latches the read data into MDR. Go to WB.
  - WB: done=1 (err=1 if illegal). R-type writes ALUOut to rd=IR[15:11]. LW writes MDR to rt. Writes occur on the exit edge. Go to IDLE.
- Writes to r0 are discarded.
- ADD and SUB wrap modulo 2^DATA_W; no overflow detection.
- While instr_ready=0, instr and instr_valid are ignored.

## Timing
- Reset values:
  - FSM state: IDLE.
  - instr_ready=1 in the cycle after reset.
  - done=0, err=0, zflag=0, result=0.
  - All registers cleared to 0.
  - Data memory is not cleared.
- rst during any state returns the FSM to IDLE on that edge and aborts any pending write. The aborted instruction produces no done.
- Latency is counted from the accepting edge (instr_valid & instr_ready) to the done cycle:
  - R-type: done is high in the 3rd cycle after acceptance (DEC, EXE, WB).
  - LW/SW: done is high in the 4th cycle (DEC, EXE, MEM, WB).
  - Illegal: done is high in the 2nd cycle (DEC, WB).
- instr_ready rises in the cycle after done. Back-to-back throughput is therefore 4, 5 or 3 cycles per instruction.
- done, err, zflag and result are Moore/registered. There is no combinational path from instr to any output.
- dbg_rd reflects a write-back starting in the cycle after done.

## Configuration
- DPTR_MEM_EN:
  - Defined: LW/SW and the data memory are present, as described above.
  - Undefined: no data memory, no MEM state, and opcodes 0x23 and 0x2B are illegal (err pulse, 2-cycle latency). R-type behaviour is unchanged.

## Test plan
- Reset, then with r1=5 and r2=7 loaded via LW (pre-initialised memory): ADD r3,r1,r2 -> done 3 cycles after acceptance, dbg_rd(r3)=12, zflag=0, result=12.
- SUB r4,r1,r1 -> r4=0 and zflag=1. SLT r5,r1,r2 -> 1. SLT with r1=-1 (all ones) and r2=0 -> 1 (signed).
- SW r2,4(r0), then LW r6,4(r0) -> done 4 cycles after each acceptance, r6=7. An address of DMEM_DEPTH+4 aliases to word 4.
- Illegal funct 0x3F, or opcode 0x08 -> err=done=1 for one cycle, 2-cycle latency, no register change, result and zflag unchanged.
- ADD r0,r1,r2 -> r0 reads 0. With DATA_W=8: 0xFF+0x01 -> 0x00, zflag=1.
- Assert rst during EXE of ADD r7,... -> r7 remains 0, no done, instr_ready=1 in the cycle after reset. Holding instr_valid during busy states is ignored, with exactly one acceptance per IDLE.
